seq_mult_rr_sched: RTL
======================

Name: seq_mult_rr_sched

Overview:
- Round-robin scheduler that shares one unsigned right-shifting shift-add multiplier between NREQ requesters.
- Each requester issues operand pairs over a valid/ready handshake. The block arbitrates, sequences the multiply bit by bit, and returns the product on one shared response channel tagged with the requester id.
- Sits between the client blocks and the multiply engine; the engine is internal, so the block is self-contained.

Parameters:
- W, 6, operand width in bits; product is 2*W bits.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, id width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high in any cycle.
- req_a  input  NREQ*W  flattened multiplicands; requester i uses bits [i*W +: W].
- req_b  input  NREQ*W  flattened multipliers, same packing.
- rsp_valid  output  1  product valid.
- rsp_ready  input  1  consumer accepts product.
- rsp_id  output  IDW  index of the requester whose product is presented.
- rsp_product  output  2*W  unsigned product a*b.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, MULT, DONE.
- Reset (rst=1 at an edge), regardless of state:
  - state=IDLE, rr_ptr=0, bit counter=0, accumulator=0, operand registers=0.
  - Outputs: rsp_valid=0, rsp_id=0, rsp_product=0, busy=0, req_ready=0.
- Reset mid-operation: the in-flight multiply is discarded and no response is produced. The requester already completed its handshake, so it must not expect a result.
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready is combinational and one-hot at the winner, asserted only in IDLE and only when some req_valid is high.
  - At that edge: latch a, b and the winner id; clear the accumulator and counter; go to MULT.
  - No request: stay in IDLE.
- MULT (exactly W cycles, counter 0..W-1):
  - Each cycle: tmp(W+1 bits) = acc + (b[counter] ? a : 0).
  - product[counter] = tmp[0]; acc = tmp >> 1; counter increments.
  - After counter W-1: product[2W-1:W] = acc[W-1:0]; go to DONE.
  - Latency is fixed. Zero operands still take W cycles with no early exit.
- DONE:
  - rsp_valid=1; rsp_product and rsp_id stay stable until rsp_ready=1.
  - On the accepting edge: rsp_valid falls, rr_ptr = (winner+1) mod NREQ, state=IDLE.
  - req_ready is 0 in DONE and MULT. A new request is accepted at the earliest one cycle after the response handshake.
- Timing: accept at edge k -> rsp_valid high after edge k+W. Minimum issue interval is W+2 cycles.
- Back-pressure: rsp_ready low holds DONE indefinitely, and all requests stall.
- Requester rules:
  - Must hold req_a, req_b and req_valid until its req_ready handshake.
  - Changing operands while valid and not yet accepted is a protocol violation; behaviour is undefined.
- Arithmetic: unsigned only; no overflow possible, since max (2^W-1)^2 fits in 2W bits.
- rr_ptr advances only on a completed response, never on reset release alone.

Test Plan:
- Reset, then requester 0 sends a=6'd5, b=6'd7 -> req_ready[0] pulses one cycle; rsp_valid rises exactly 6 cycles after the accept edge; rsp_product=12'd35, rsp_id=0.
- Requester 2 sends a=63, b=63 with rsp_ready held low for 4 cycles -> rsp_product=12'd3969 (0xF81), rsp_id=2, outputs stable for all 4 held cycles; busy stays 1 until the handshake.
- Requesters 0, 1, 3 all hold valid continuously with distinct operands (e.g. 3*4, 10*10, 0*63) -> service order 0, 1, 3, 0, ...; results 12, 100, 0; the zero product still takes 6 MULT cycles; req_ready is never more than one-hot.
- After requester 3 is served, requesters 0 and 3 are both valid -> requester 0 wins (pointer wrapped to 0).
- Assert rst for one cycle during the 3rd MULT cycle of 9*9 -> no rsp_valid, all outputs 0, busy 0; the next request from requester 1 (2*3) returns 6 with rsp_id=1.
- Exhaustive sweep from a single requester over all 4096 (a, b) pairs -> every rsp_product equals a*b; each transaction takes W+2 cycles from accept to the next possible accept.

Source files
------------

// File: rtl/seq_mult_rr_sched.sv
// Round-robin front end sharing one right-shifting shift-add multiplier among NREQ requesters.
// Products return on a single response channel, tagged with the requester id.
module seq_mult_rr_sched #(
    parameter int W    = 6,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [2*W-1:0]      rsp_product,
    output logic                busy
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [IDW-1:0]  rr_ptr_r;
    logic [CW-1:0]   cnt_r;
    logic [W-1:0]    acc_r;
    logic [W-1:0]    lo_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W:0]      tmp_s;

    logic            found_s;
    logic [IDW-1:0]  winner_s;
    logic [W-1:0]    a_sel_s;
    logic [W-1:0]    b_sel_s;
    int              best_s;
    int              dist_s;

    // The product is the accumulator (high half) above the collected low bits.
    assign rsp_product = {acc_r, lo_r};

    // Arbitration: pick the valid requester closest to rr_ptr going upward, wrapping.
    always_comb begin
        best_s   = NREQ;
        dist_s   = 0;
        winner_s = '0;
        a_sel_s  = '0;
        b_sel_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            dist_s = (i + NREQ - int'(rr_ptr_r)) % NREQ;
            if (req_valid[i] && (dist_s < best_s)) begin
                best_s   = dist_s;
                winner_s = IDW'(i);
                a_sel_s  = req_a[i*W +: W];
                b_sel_s  = req_b[i*W +: W];
            end else begin
                best_s   = best_s;
            end
        end
        found_s = (best_s < NREQ);
    end

    // One-hot accept strobe, only offered while idle and out of reset.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!rst && (state_r == IDLE) && found_s && (winner_s == IDW'(i))) begin
                req_ready[i] = 1'b1;
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    // One shift-add step: add the multiplicand when the current multiplier bit is set.
    always_comb begin
        if (b_r[cnt_r]) begin
            tmp_s = {1'b0, acc_r} + {1'b0, a_r};
        end else begin
            tmp_s = {1'b0, acc_r};
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            rr_ptr_r  <= '0;
            cnt_r     <= '0;
            acc_r     <= '0;
            lo_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        a_r     <= a_sel_s;
                        b_r     <= b_sel_s;
                        rsp_id  <= winner_s;
                        acc_r   <= '0;
                        lo_r    <= '0;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= MULT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MULT: begin
                    lo_r[cnt_r] <= tmp_s[0];
                    acc_r       <= tmp_s[W:1];
                    cnt_r       <= cnt_r + CW'(1);
                    if (cnt_r == CW'(W - 1)) begin
                        rsp_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        state_r   <= MULT;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                        if (rsp_id == IDW'(NREQ - 1)) begin
                            rr_ptr_r <= '0;
                        end else begin
                            rr_ptr_r <= rsp_id + IDW'(1);
                        end
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule
